// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - circular-buffer issue queue, 4-wide enqueue, 2-wide issue
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   issue_queue_element[3:0] up to four decoded instructions to enqueue, slot 0 oldest
//   issue_queue_push_number  slots to enqueue this cycle (0..4; larger is rejected)
//   iq_size_left             free entries, saturated at 4
//   issue_element[1:0]       two oldest entries, slot 0 oldest
//   issue_valid[1:0]         per-slot valid for issue_element
//   issue_pop_number         entries consumed by the issue stage (3 treated as 2)
//   flush                    discard every entry
//   overflow_err             one-cycle pulse after a rejected push
module issue_queue #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0][WIDTH-1:0] issue_queue_element,
    input  logic [2:0]            issue_queue_push_number,
    output logic [2:0]            iq_size_left,
    output logic [1:0][WIDTH-1:0] issue_element,
    output logic [1:0]            issue_valid,
    input  logic [1:0]            issue_pop_number,
    input  logic                  flush,
    output logic                  overflow_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_err_q, overflow_err_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [CW-1:0]    free_entries;
    logic [1:0]       pop_req;
    logic [1:0]       eff_pop;
    logic             push_ok;

    assign free_entries = CW'(DEPTH) - count_q;
    assign iq_size_left = (free_entries > CW'(4)) ? 3'd4 : free_entries[2:0];

    // A request of 3 is clamped to the 2-wide issue width, then to what is queued.
    assign pop_req = (issue_pop_number == 2'd3) ? 2'd2 : issue_pop_number;
    assign eff_pop = (CW'(pop_req) > count_q) ? count_q[1:0] : pop_req;

    // Acceptance uses the pre-pop free space; saturation at 4 also rejects 5..7.
    assign push_ok = (issue_queue_push_number <= iq_size_left);

    assign issue_element[0] = mem_q[head_q];
    assign issue_element[1] = mem_q[head_q + PW'(1)];
    assign issue_valid[0]   = (count_q != '0);
    assign issue_valid[1]   = (count_q > CW'(1));
    assign overflow_err     = overflow_err_q;

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        overflow_err_d = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d = head_q + PW'(eff_pop);
            if (push_ok) begin
                for (int k = 0; k < 4; k++) begin
                    if (k < int'(issue_queue_push_number)) begin
                        mem_d[tail_q + PW'(k)] = issue_queue_element[k];
                    end
                end
                tail_d  = tail_q + PW'(issue_queue_push_number);
                count_d = count_q + CW'(issue_queue_push_number) - CW'(eff_pop);
            end else begin
                overflow_err_d = 1'b1;
                count_d        = count_q - CW'(eff_pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            overflow_err_q <= 1'b0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    // Payload storage needs no reset: entries outside [head, head+count) are don't-care.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end
endmodule
